// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and oversampling constants.
// The receiver uses it now, and the transmitter will use it later.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int OS_W       = $clog2(OVERSAMPLE);
  localparam int MID_START  = 7;
  localparam int MID_BIT    = 15;

endpackage

// File: rtl/uart_os_tick.sv
// Oversample strobe generator: a one-cycle tick every BAUD_DIV src_clk cycles.
// The synchronous clear realigns the tick phase to a detected start edge.
module uart_os_tick #(
  parameter int BAUD_DIV = 27
) (
  input  logic src_clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(BAUD_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_end;

  always_comb begin
    at_end = (cnt_q == CW'(BAUD_DIV - 1));
    tick   = at_end && !clr;
    if (clr || at_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with 16x oversampling and mid-bit sampling.
// It presents each good byte with a valid strobe and flags a low stop bit.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | timing to the middle of the start bit, where it rejects glitches
// DATA  | sampling DATA_BITS data bits, LSB first
// STOP  | sampling the stop bit, which sets the valid or framing-error strobe
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = 27,
  parameter int DATA_BITS = 8
) (
  input  logic                 src_clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  uart_state_e          state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 prev_q, prev_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 fall;
  logic                 tick;
  logic                 tick_clr;

  uart_os_tick #(.BAUD_DIV(BAUD_DIV)) u_os_tick (
    .src_clk (src_clk),
    .rst_n   (rst_n),
    .clr     (tick_clr),
    .tick    (tick)
  );

  always_comb begin
    sync1_d  = rx;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    fall     = prev_q && !sync2_q;
    state_d  = state_q;
    os_d     = tick ? os_q + OS_W'(1) : os_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    tick_clr = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d  = ST_START;
          tick_clr = 1'b1;
          os_d     = '0;
        end
      end
      ST_START: begin
        if (tick && os_q == OS_W'(MID_START)) begin
          if (!sync2_q) begin
            state_d = ST_DATA;
            os_d    = '0;
            bit_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick && os_q == OS_W'(MID_BIT)) begin
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      ST_STOP: begin
        // Returning at mid stop bit leaves half a bit to catch an immediately following start edge.
        if (tick && os_q == OS_W'(MID_BIT)) begin
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: it recovers 8N1 frames from the asynchronous `rx` line using 16× oversampling and mid-bit sampling. Its oversample tick is derived internally from `src_clk`. It is the receiving end of the team's custom UART link and sits between the pad-side serial input and the byte-wide host/FIFO interface. Each received byte is presented with a one-cycle valid strobe; bad stop bits are flagged with a one-cycle framing-error strobe.

## Interface
- `BAUD_DIV`, default 27: `src_clk` cycles per oversample tick; bit period = 16·`BAUD_DIV` cycles (50 MHz / 115200 baud). Legal range is ≥ 2.
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `src_clk`, in, 1: single system clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rx`, in, 1: serial line; idle high; asynchronous to `src_clk`.
- `data_out`, out, `DATA_BITS`: last correctly framed byte; holds its value until the next good frame.
- `data_valid`, out, 1: one-cycle pulse when `data_out` is updated.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- Input path: `rx` goes through a 2-flop synchronizer, and both flops reset to 1. A third registered copy provides falling-edge detection.
- Tick generator: a counter runs 0..`BAUD_DIV`-1 and pulses `tick` when it reaches `BAUD_DIV`-1. It is cleared to 0 on a start edge in IDLE. It runs freely otherwise.
- Oversample counter: 4 bits. It increments on each tick and wraps 15→0. It is cleared together with the tick counter.
- The bit counter counts 0..`DATA_BITS`-1.
- State machine:
  - IDLE → START on a falling edge of the synchronized `rx`.
  - START: on the tick where the oversample counter reaches 7 (mid start bit):
    - if `rx` is 0, clear the oversample counter and go to DATA;
    - if `rx` is 1, treat it as a glitch and return to IDLE with no outputs.
  - DATA: on each tick where the oversample counter reaches 15 (mid-bit):
    - shift `rx` into the MSB of the shift register (LSB-first reception);
    - after `DATA_BITS` samples, go to STOP.
  - STOP: on the tick where the oversample counter reaches 15 (mid stop bit):
    - if `rx` is 1, load `data_out` from the shift register and pulse `data_valid`;
    - if `rx` is 0, pulse `frame_err` and leave `data_out` unchanged;
    - in both cases go to IDLE.
- Return to IDLE happens at mid stop bit, so a start bit immediately following the stop bit is caught.
- After a framing error on a held-low line (break), no new frame is accepted until `rx` rises and then falls again.
- `data_valid` and `frame_err` are never asserted in the same cycle.

## Timing
- Reset values:
  - `data_out` = 0, `data_valid` = 0, `frame_err` = 0, `busy` = 0;
  - state = IDLE;
  - all counters = 0;
  - synchronizer flops = 1.
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately with no strobe. After release, the block waits for a fresh falling edge.
- Edge detection takes 3 `src_clk` cycles after the `rx` pin falls: 2 synchronizer stages plus the edge register.
- Start-bit sample: 8·`BAUD_DIV` cycles after edge detection.
- Data bit k sample: (8 + 16·(k+1))·`BAUD_DIV` cycles after edge detection.
- `data_valid`/`frame_err` are registered. They rise (152·`BAUD_DIV` + 3) ±1 cycles after the `rx` pin falls, for `DATA_BITS` = 8.
- `busy` rises 1 cycle after edge detection and falls in the same cycle the strobe rises.
- Required tolerance: correct reception with transmitter baud error up to ±3 %.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE, START, DATA, STOP, 2 bits);
  - `OVERSAMPLE` = 16;
  - `MID_START` = 7;
  - `MID_BIT` = 15.
  The future `uart_tx` uses the same package.
- One sub-module, `uart_os_tick`, holds the `BAUD_DIV` counter with synchronous clear and the `tick` output. It is distinct from the existing clock-divider prescaler: it produces a strobe, not a derived clock.

## Test plan
Common bench setup: `BAUD_DIV` = 4, so one bit = 64 cycles; 8N1 driver model.

1. Good frame: send 0xA5 → `data_out` = 0xA5 and exactly one `data_valid` pulse at 611 ±1 cycles after the start edge; `frame_err` stays 0.
2. Glitch: drive `rx` low for 16 cycles, then high → no strobes, `busy` returns to 0, and a following 0x5A frame is received correctly.
3. Framing error: send 0x3C with the stop bit forced to 0 → one `frame_err` pulse and `data_out` still 0xA5. Then release `rx` high and send 0x81 → `data_out` = 0x81.
4. Back-to-back: send 0x00 then 0xFF with zero idle time between them → two `data_valid` pulses, 640 cycles apart, carrying 0x00 then 0xFF.
5. Reset mid-frame: assert `rst_n` low during data bit 3 of 0x77 → all outputs 0 immediately and no strobe. After release, 0x42 is received correctly.
6. Baud skew: send 0xC3 at bit periods of 62 and 66 cycles → `data_out` = 0xC3 in both cases, with no `frame_err`.
